// File: rtl/serial_adder.sv
// Multi-cycle adder: WIDTH-bit a + b + cin, DIGIT bits per clock, carry held
// between digits. Start/busy/done handshake; sum/cout/ovf held until next result.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int N = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  // Encoding chosen so busy and done come straight off state flops.
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] sh_a, sh_b, psum_nxt;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [DIGIT:0]   dsum;
  logic             msb_cin;
  logic             accept, last;

  assign accept  = start && (state != RUN);
  assign last    = (state == RUN) && (cnt == LAST);
  assign dsum    = {1'b0, sh_a[DIGIT-1:0]} + {1'b0, sh_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
  // Carry into the top bit of the current digit: sum bit = a ^ b ^ carry_in.
  assign msb_cin = sh_a[DIGIT-1] ^ sh_b[DIGIT-1] ^ dsum[DIGIT-1];

  generate
    if (WIDTH > DIGIT) begin : g_multi
      logic [WIDTH-DIGIT-1:0] psum;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              psum <= '0;
        else if (state == RUN)   psum <= psum_nxt[WIDTH-1:DIGIT];
      end
      assign psum_nxt = {dsum[DIGIT-1:0], psum};
    end else begin : g_single
      assign psum_nxt = dsum[DIGIT-1:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last)   state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = state[0];
    done = state[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a  <= '0;
      sh_b  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      sh_a  <= a;
      sh_b  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      sh_a  <= sh_a >> DIGIT;
      sh_b  <= sh_b >> DIGIT;
      carry <= dsum[DIGIT];
      cnt   <= cnt + 1'b1;
      if (last) begin
        sum  <= psum_nxt;
        cout <= dsum[DIGIT];
        ovf  <= msb_cin ^ dsum[DIGIT];
      end
    end
  end
endmodule
